// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing bundle type, idle value and delay clamp helper
package vga_pkg;

   localparam int VGA_WIDTH = 11;

   typedef struct packed {
      logic                 hsync;
      logic                 vsync;
      logic [VGA_WIDTH-1:0] hdata;
      logic [VGA_WIDTH-1:0] vdata;
      logic                 de;
   } vga_timing_t;

   function automatic vga_timing_t vga_idle(input logic hs, input logic vs);
      vga_timing_t t;
      t       = '0;
      t.hsync = hs;
      t.vsync = vs;
      return t;
   endfunction

   function automatic int vga_clamp(input int v, input int lo, input int hi);
      if (v < lo)
         return lo;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

endpackage

// File: rtl/vga_delay_stage.sv
// rtl/vga_delay_stage.sv - one bundle register with clock enable and synchronous reset-to-idle
module vga_delay_stage #(
   parameter int           W    = 25,
   parameter logic [W-1:0] IDLE = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= IDLE;
      else if (ce)
         q <= d;
   end

endmodule

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - run-time selectable delay line for the VGA timing bundle
// Optional: define VGA_DELAY_BLANK_EN to zero coordinates whenever the delayed de is low.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int   WIDTH      = VGA_WIDTH,
   parameter int   MAX_DEPTH  = 8,
   parameter logic HSYNC_IDLE = 1'b1,
   parameter logic VSYNC_IDLE = 1'b1,
   localparam int  DW         = $clog2(MAX_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [DW-1:0]    in_delay,
   input  logic             in_hsync,
   input  logic             in_vsync,
   input  logic [WIDTH-1:0] in_hdata,
   input  logic [WIDTH-1:0] in_vdata,
   input  logic             in_de,
   output logic             out_hsync,
   output logic             out_vsync,
   output logic [WIDTH-1:0] out_hdata,
   output logic [WIDTH-1:0] out_vdata,
   output logic             out_de,
   output logic             out_valid
);

   typedef struct packed {
      logic             hsync;
      logic             vsync;
      logic [WIDTH-1:0] hdata;
      logic [WIDTH-1:0] vdata;
      logic             de;
   } bundle_t;

   localparam int          BW       = $bits(bundle_t);
   localparam vga_timing_t IDLE_REF = vga_idle(HSYNC_IDLE, VSYNC_IDLE);
   localparam bundle_t     IDLE     = '{hsync: IDLE_REF.hsync, vsync: IDLE_REF.vsync,
                                        hdata: '0, vdata: '0, de: IDLE_REF.de};

   bundle_t       in_bundle;
   bundle_t       tap;
   bundle_t       out_bundle;
   logic [BW-1:0] stage_q [MAX_DEPTH];
   logic [DW-1:0] delay_q;
   logic [DW-1:0] delay_new;
   logic [DW-1:0] fc;

   assign in_bundle = '{hsync: in_hsync, vsync: in_vsync, hdata: in_hdata,
                        vdata: in_vdata, de: in_de};
   assign delay_new = DW'(vga_clamp(int'(in_delay), 1, MAX_DEPTH));

   for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
         vga_delay_stage #(.W(BW), .IDLE(IDLE)) u_stage (
            .clk (clk),
            .rst (rst),
            .ce  (ce),
            .d   (in_bundle),
            .q   (stage_q[k])
         );
      end else begin : g_next
         vga_delay_stage #(.W(BW), .IDLE(IDLE)) u_stage (
            .clk (clk),
            .rst (rst),
            .ce  (ce),
            .d   (stage_q[k-1]),
            .q   (stage_q[k])
         );
      end
   end

   // A shrink keeps the fill count (capped at the new depth) since every stage holds
   // real data; a grow leaves it alone so the deeper stages must fill first.
   always_ff @(posedge clk) begin
      if (rst) begin
         fc      <= '0;
         delay_q <= delay_new;
      end else if (ce) begin
         if (delay_new != delay_q) begin
            delay_q <= delay_new;
            if (delay_new < delay_q && fc > delay_new)
               fc <= delay_new;
         end else if (fc < delay_q) begin
            fc <= fc + DW'(1);
         end
      end
   end

   assign out_valid = (fc >= delay_q);

   always_comb begin
      tap = IDLE;
      for (int k = 0; k < MAX_DEPTH; k++) begin
         if (delay_q == DW'(k + 1))
            tap = bundle_t'(stage_q[k]);
      end
   end

   always_comb begin
      out_bundle = out_valid ? tap : IDLE;
`ifdef VGA_DELAY_BLANK_EN
      if (!out_bundle.de) begin
         out_bundle.hdata = '0;
         out_bundle.vdata = '0;
      end
`else
`endif
   end

   assign out_hsync = out_bundle.hsync;
   assign out_vsync = out_bundle.vsync;
   assign out_hdata = out_bundle.hdata;
   assign out_vdata = out_bundle.vdata;
   assign out_de    = out_bundle.de;

endmodule

// File: tb/tb_vga_delay_line.sv
// tb/tb_vga_delay_line.sv - self-checking bench for vga_delay_line against a queue-based reference
module tb_vga_delay_line;

   localparam int WIDTH = 11;
   localparam int MAXD  = 8;
   localparam int DW    = 4;
   localparam logic [24:0] IDLE_V = {1'b1, 1'b1, 22'd0, 1'b0};

   logic             clk = 1'b0;
   logic             rst;
   logic             ce;
   logic [DW-1:0]    in_delay;
   logic             in_hsync, in_vsync, in_de;
   logic [WIDTH-1:0] in_hdata, in_vdata;
   logic             out_hsync, out_vsync, out_de, out_valid;
   logic [WIDTH-1:0] out_hdata, out_vdata;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [24:0] hist [MAXD];
   int          ref_fc;
   int          ref_delay;

   vga_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_delay  (in_delay),
      .in_hsync  (in_hsync),
      .in_vsync  (in_vsync),
      .in_hdata  (in_hdata),
      .in_vdata  (in_vdata),
      .in_de     (in_de),
      .out_hsync (out_hsync),
      .out_vsync (out_vsync),
      .out_hdata (out_hdata),
      .out_vdata (out_vdata),
      .out_de    (out_de),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   function automatic int clampd(input int d);
      if (d < 1) return 1;
      if (d > MAXD) return MAXD;
      return d;
   endfunction

   function automatic logic [25:0] exp_vec();
      logic [24:0] b;
      if (ref_fc >= ref_delay) begin
         b = hist[ref_delay-1];
`ifdef VGA_DELAY_BLANK_EN
         if (!b[0]) b[22:1] = '0;
`endif
         return {1'b1, b};
      end
      return {1'b0, IDLE_V};
   endfunction

   function automatic logic [25:0] act_vec();
      return {out_valid, out_hsync, out_vsync, out_hdata, out_vdata, out_de};
   endfunction

   task automatic rand_in();
      in_hsync = 1'($urandom);
      in_vsync = 1'($urandom);
      in_hdata = WIDTH'($urandom);
      in_vdata = WIDTH'($urandom);
      in_de    = 1'($urandom);
   endtask

   // Advance one clock, update the reference model from the sampled inputs, settle.
   task automatic tick();
      int nd;
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < MAXD; k++) hist[k] = IDLE_V;
         ref_fc    = 0;
         ref_delay = clampd(int'(in_delay));
      end else if (ce) begin
         nd = clampd(int'(in_delay));
         for (int k = MAXD - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = {in_hsync, in_vsync, in_hdata, in_vdata, in_de};
         if (nd != ref_delay) begin
            if (nd < ref_delay && ref_fc > nd) ref_fc = nd;
            ref_delay = nd;
         end else if (ref_fc < ref_delay) begin
            ref_fc = ref_fc + 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b1; in_delay = 4'd3;
      rand_in();
      tick();
      tick();
      n_cmp++;
      if (act_vec() !== {1'b0, IDLE_V}) begin
         n_fail++;
         $display("FAIL reset_idle: got %h expected %h", act_vec(), {1'b0, IDLE_V});
      end
   endtask

   task automatic test_fill();
      rst = 1'b1; ce = 1'b1; in_delay = 4'd3;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         rand_in();
         in_de = 1'b1;
         in_hdata = WIDTH'(i - 1);
         tick();
         n_cmp++;
         if (out_valid !== (i >= 3)) begin
            n_fail++;
            $display("FAIL fill_valid[%0d]: got %b expected %b", i, out_valid, (i >= 3));
         end
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fill_bundle[%0d]: got %h expected %h", i, act_vec(), exp_vec());
         end
         if (i >= 3) begin
            n_cmp++;
            if (out_hdata !== WIDTH'(i - 3)) begin
               n_fail++;
               $display("FAIL fill_latency[%0d]: got %0d expected %0d", i, out_hdata, i - 3);
            end
         end
      end
   endtask

   task automatic test_clamp();
      int reqs [2];
      int lats [2];
      int first;
      reqs[0] = 0;  lats[0] = 1;
      reqs[1] = 15; lats[1] = MAXD;
      for (int t = 0; t < 2; t++) begin
         rst = 1'b1; ce = 1'b1; in_delay = DW'(reqs[t]);
         tick();
         rst = 1'b0;
         first = 0;
         for (int i = 1; i <= 12; i++) begin
            rand_in();
            in_de = 1'b1;
            tick();
            if (out_valid && first == 0) first = i;
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL clamp_bundle[%0d/%0d]: got %h expected %h", reqs[t], i, act_vec(), exp_vec());
            end
         end
         n_cmp++;
         if (first != lats[t]) begin
            n_fail++;
            $display("FAIL clamp_latency[%0d]: got %0d expected %0d", reqs[t], first, lats[t]);
         end
      end
   endtask

   task automatic test_delay_change();
      logic [WIDTH-1:0] sent [$];
      int low;
      bit seen;
      rst = 1'b1; ce = 1'b1; in_delay = 4'd2;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rand_in(); in_de = 1'b1; sent.push_back(in_hdata);
         tick();
      end
      in_delay = 4'd5;
      low = 0; seen = 0;
      for (int i = 0; i < 10; i++) begin
         rand_in(); in_de = 1'b1; sent.push_back(in_hdata);
         tick();
         if (!out_valid && !seen) low++;
         if (out_valid) seen = 1;
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL grow_bundle[%0d]: got %h expected %h", i, act_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (low != 3) begin
         n_fail++;
         $display("FAIL grow_invalid_cycles: got %0d expected 3", low);
      end
      in_delay = 4'd2;
      rand_in(); in_de = 1'b1; sent.push_back(in_hdata);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL shrink_valid: got %b expected 1", out_valid);
      end
      n_cmp++;
      if (out_hdata !== sent[sent.size()-2]) begin
         n_fail++;
         $display("FAIL shrink_latency: got %h expected %h", out_hdata, sent[sent.size()-2]);
      end
   endtask

   task automatic test_ce_stall();
      logic [WIDTH-1:0] sent [$];
      logic [25:0] prev;
      bit pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      rst = 1'b1; ce = 1'b1; in_delay = 4'd4;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rand_in(); in_de = 1'b1; sent.push_back(in_hdata);
         tick();
      end
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < 4; p++) begin
            ce = pat[p];
            rand_in(); in_de = 1'b1;
            if (ce) sent.push_back(in_hdata);
            in_delay = ce ? 4'd4 : DW'($urandom_range(0, 15));
            prev = act_vec();
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL stall_bundle[%0d.%0d]: got %h expected %h", r, p, act_vec(), exp_vec());
            end
            if (!ce) begin
               n_cmp++;
               if (act_vec() !== prev) begin
                  n_fail++;
                  $display("FAIL stall_frozen[%0d.%0d]: got %h expected %h", r, p, act_vec(), prev);
               end
            end else begin
               n_cmp++;
               if (out_hdata !== sent[sent.size()-4]) begin
                  n_fail++;
                  $display("FAIL stall_latency[%0d.%0d]: got %h expected %h", r, p, out_hdata, sent[sent.size()-4]);
               end
            end
         end
      end
      ce = 1'b1; in_delay = 4'd4;
   endtask

   task automatic test_mid_reset();
      rst = 1'b1; ce = 1'b1; in_delay = 4'd3;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_in(); in_de = 1'b1;
         tick();
      end
      rst = 1'b1;
      rand_in();
      tick();
      n_cmp++;
      if (act_vec() !== {1'b0, IDLE_V}) begin
         n_fail++;
         $display("FAIL midreset_idle: got %h expected %h", act_vec(), {1'b0, IDLE_V});
      end
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         rand_in(); in_de = 1'b1;
         tick();
         n_cmp++;
         if (out_valid !== (i >= 3)) begin
            n_fail++;
            $display("FAIL refill_valid[%0d]: got %b expected %b", i, out_valid, (i >= 3));
         end
      end
   endtask

   task automatic test_blank();
      logic [WIDTH-1:0] exp_hd;
`ifdef VGA_DELAY_BLANK_EN
      exp_hd = '0;
`else
      exp_hd = 11'h155;
`endif
      rst = 1'b1; ce = 1'b1; in_delay = 4'd1;
      tick();
      rst = 1'b0;
      in_hsync = 1'b0; in_vsync = 1'b1; in_de = 1'b0;
      in_hdata = 11'h155; in_vdata = 11'h2aa;
      tick();
      tick();
      n_cmp++;
      if ({out_valid, out_de, out_hdata} !== {1'b1, 1'b0, exp_hd}) begin
         n_fail++;
         $display("FAIL blank_hdata: got v=%b de=%b hd=%h expected v=1 de=0 hd=%h", out_valid, out_de, out_hdata, exp_hd);
      end
   endtask

   task automatic test_random();
      rst = 1'b1; ce = 1'b1; in_delay = DW'($urandom_range(0, 15));
      tick();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         ce  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) in_delay = DW'($urandom_range(0, 15));
         rand_in();
         tick();
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_bundle[%0d]: got %h expected %h", i, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; in_delay = '0;
      in_hsync = 1'b0; in_vsync = 1'b0; in_hdata = '0; in_vdata = '0; in_de = 1'b0;
      test_reset();
      test_fill();
      test_clamp();
      test_delay_change();
      test_ce_stall();
      test_mid_reset();
      test_blank();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
